// File: rtl/coin_selector_pkg.sv
// rtl/coin_selector_pkg.sv - cafe_pkg: drink/coin/state types, prices and helper functions
package cafe_pkg;

    localparam int CREDIT_W = 8;

    localparam logic [CREDIT_W-1:0] PRICE_CAFE  = 8'd100;
    localparam logic [CREDIT_W-1:0] PRICE_DUPLO = 8'd150;
    localparam logic [CREDIT_W-1:0] PRICE_LEITE = 8'd175;
    // Ceiling kept one bit wider so it compares directly against the 9-bit sum.
    localparam logic [CREDIT_W:0]   MAX_CREDIT  = 9'd250;

    typedef enum logic [1:0] {
        CAFE   = 2'd0,
        DUPLO  = 2'd1,
        LEITE  = 2'd2,
        NENHUM = 2'd3
    } drink_t;

    typedef enum logic [1:0] {
        COIN_25  = 2'd0,
        COIN_50  = 2'd1,
        COIN_100 = 2'd2,
        COIN_BAD = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    function automatic logic [CREDIT_W-1:0] price_of(input drink_t d);
        case (d)
            CAFE:    price_of = PRICE_CAFE;
            DUPLO:   price_of = PRICE_DUPLO;
            LEITE:   price_of = PRICE_LEITE;
            default: price_of = '0;
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_cents(input coin_t c);
        case (c)
            COIN_25:  coin_cents = 8'd25;
            COIN_50:  coin_cents = 8'd50;
            COIN_100: coin_cents = 8'd100;
            default:  coin_cents = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_selector_if.sv
// rtl/coin_selector_if.sv - front-panel / coffee-machine signal bundle for coin_selector
interface coin_selector_if;
    import cafe_pkg::*;

    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                sel_valid;
    logic [1:0]          sel_drink;
    logic                cancel;
    logic                brew_done;
    logic [1:0]          tipo;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic                coin_reject;
    logic                err_insufficient;
    logic                fault;

    modport master (
        output coin_valid, coin_code, sel_valid, sel_drink, cancel, brew_done,
        input  tipo, credit, busy, change_valid, change_amount,
               coin_reject, err_insufficient, fault
    );

    modport slave (
        input  coin_valid, coin_code, sel_valid, sel_drink, cancel, brew_done,
        output tipo, credit, busy, change_valid, change_amount,
               coin_reject, err_insufficient, fault
    );
endinterface

// File: rtl/coin_selector_coin_decoder.sv
// rtl/coin_selector_coin_decoder.sv - coin_decoder: coin code to cents plus valid flag
module coin_decoder
    import cafe_pkg::*;
(
    input  logic [1:0]          i_coin_code,
    output logic [CREDIT_W-1:0] o_cents,
    output logic                o_valid
);
    assign o_cents = coin_cents(coin_t'(i_coin_code));
    assign o_valid = (coin_t'(i_coin_code) != COIN_BAD);
endmodule

// File: rtl/coin_selector.sv
// rtl/coin_selector.sv - coin credit / drink selection FSM feeding the coffee machine; optional watchdog under DONE_TIMEOUT_EN
module coin_selector
    import cafe_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    coin_selector_if.slave bus
);

    state_t              r_state;
    logic [1:0]          r_tipo;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_busy;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_amount;
    logic                r_coin_reject;
    logic                r_err_insufficient;

    logic [CREDIT_W-1:0] w_cents;
    logic                w_code_ok;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_credit_next;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_sel_req;

    coin_decoder u_coin_decoder (
        .i_coin_code (bus.coin_code),
        .o_cents     (w_cents),
        .o_valid     (w_code_ok)
    );

    // Coin acceptance uses a 9-bit sum so the ceiling compare cannot wrap.
    assign w_sum         = {1'b0, r_credit} + {1'b0, w_cents};
    assign w_coin_ok     = bus.coin_valid && w_code_ok && (w_sum <= MAX_CREDIT);
    assign w_credit_next = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
    assign w_sel_req     = bus.sel_valid && (drink_t'(bus.sel_drink) != NENHUM);
    assign w_sel_price   = price_of(drink_t'(bus.sel_drink));

`ifdef DONE_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_CYCLES = 12'd4000;

    logic [11:0]       r_wd;
    logic              r_fault;
    logic [CREDIT_W:0] w_refund;

    // Full refund of the drink in progress, saturated at the credit ceiling.
    assign w_refund = {1'b0, r_credit} + {1'b0, price_of(drink_t'(r_tipo))};
`endif

    // Main FSM: credit accounting, drink request handshake and change return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= IDLE;
            r_tipo             <= 2'(NENHUM);
            r_credit           <= '0;
            r_busy             <= 1'b0;
            r_change_valid     <= 1'b0;
            r_change_amount    <= '0;
            r_coin_reject      <= 1'b0;
            r_err_insufficient <= 1'b0;
`ifdef DONE_TIMEOUT_EN
            r_wd               <= '0;
            r_fault            <= 1'b0;
`endif
        end else begin
            r_change_valid     <= 1'b0;
            r_coin_reject      <= 1'b0;
            r_err_insufficient <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tipo        <= 2'(NENHUM);
                    r_busy        <= 1'b0;
                    r_coin_reject <= bus.coin_valid && !w_coin_ok;
                    if (bus.cancel) begin
                        // A coin landing with cancel is accepted and refunded with the rest.
                        r_change_valid  <= (w_credit_next != '0);
                        r_change_amount <= w_credit_next;
                        r_credit        <= '0;
                    end else if (w_sel_req) begin
                        if (w_credit_next >= w_sel_price) begin
                            r_credit <= w_credit_next - w_sel_price;
                            r_tipo   <= bus.sel_drink;
                            r_busy   <= 1'b1;
                            r_state  <= DISPENSE;
`ifdef DONE_TIMEOUT_EN
                            r_wd     <= '0;
`endif
                        end else begin
                            r_err_insufficient <= 1'b1;
                            r_credit           <= w_credit_next;
                        end
                    end else begin
                        r_credit <= w_credit_next;
                    end
                end
                DISPENSE: begin
                    r_coin_reject <= bus.coin_valid;
                    if (bus.brew_done) begin
                        // Drop the request on the same edge so the machine idles instead of rebrewing.
                        r_tipo  <= 2'(NENHUM);
                        r_busy  <= 1'b0;
                        r_state <= CHANGE;
`ifdef DONE_TIMEOUT_EN
                    end else if (r_wd == TIMEOUT_CYCLES - 12'd1) begin
                        r_tipo   <= 2'(NENHUM);
                        r_busy   <= 1'b0;
                        r_credit <= (w_refund > MAX_CREDIT) ? MAX_CREDIT[CREDIT_W-1:0]
                                                            : w_refund[CREDIT_W-1:0];
                        r_fault  <= 1'b1;
                        r_state  <= CHANGE;
                    end else begin
                        r_wd <= r_wd + 12'd1;
`endif
                    end
                end
                CHANGE: begin
                    r_coin_reject   <= bus.coin_valid;
                    r_change_valid  <= (r_credit != '0);
                    r_change_amount <= r_credit;
                    r_credit        <= '0;
                    r_state         <= IDLE;
                end
                default: begin
                    r_tipo  <= 2'(NENHUM);
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tipo             = r_tipo;
    assign bus.credit           = r_credit;
    assign bus.busy             = r_busy;
    assign bus.change_valid     = r_change_valid;
    assign bus.change_amount    = r_change_amount;
    assign bus.coin_reject      = r_coin_reject;
    assign bus.err_insufficient = r_err_insufficient;
`ifdef DONE_TIMEOUT_EN
    assign bus.fault            = r_fault;
`else
    assign bus.fault            = 1'b0;
`endif

endmodule
